// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direction and target predictor.
//
// A direct-mapped table of 2-bit saturating counters (BHT) and a tagged,
// direct-mapped branch target buffer (BTB) are looked up combinationally for
// each of the two fetch slots. The two-wide retire stream trains both tables
// and drives the branch and mispredict performance counters.
//
// Ports:
//   clock                    single clock, all state changes on rising edge
//   reset                    synchronous, active-low clear
//   if_valid[1:0]            fetch slot valid
//   if_pc[2*XLEN-1:0]        fetch slot PCs, slot s at [s*XLEN +: XLEN]
//   predict_take_branch[1:0] predicted taken per fetch slot
//   predict_target_pc        predicted next PC per fetch slot
//   ret_valid[1:0]           retire slot holds a retiring branch (slot 0 older)
//   ret_pc                   PC of each retiring branch
//   ret_ex_take_branch       resolved direction
//   ret_ex_target_pc         resolved taken target
//   ret_predict_take_branch  direction predicted at fetch
//   branch_count             branches used for training (wraps)
//   mispredict_count         cycles with a counted direction mispredict (wraps)
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        if_valid,
    input  logic [2*XLEN-1:0] if_pc,
    output logic [1:0]        predict_take_branch,
    output logic [2*XLEN-1:0] predict_target_pc,
    input  logic [1:0]        ret_valid,
    input  logic [2*XLEN-1:0] ret_pc,
    input  logic [1:0]        ret_ex_take_branch,
    input  logic [2*XLEN-1:0] ret_ex_target_pc,
    input  logic [1:0]        ret_predict_take_branch,
    output logic [31:0]       branch_count,
    output logic [31:0]       mispredict_count
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;

    logic [1:0]             bht        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Lookup: a hit needs a valid, tag-matching BTB entry and a taken-leaning
    // counter (upper bit set means counter >= 2).
    for (genvar s = 0; s < 2; s++) begin : g_lookup
        logic [XLEN-1:0]   pc;
        logic [BHT_IW-1:0] bi;
        logic [BTB_IW-1:0] ti;
        logic              hit;
        assign pc  = if_pc[s*XLEN +: XLEN];
        assign bi  = pc[BHT_IW+1:2];
        assign ti  = pc[BTB_IW+1:2];
        assign hit = if_valid[s] & btb_valid[ti] &
                     (btb_tag[ti] == pc[XLEN-1:BTB_IW+2]) & bht[bi][1];
        assign predict_take_branch[s]             = hit;
        assign predict_target_pc[s*XLEN +: XLEN] = hit ? btb_target[ti] : pc + XLEN'(4);
    end

    // Retire decode
    logic [XLEN-1:0]   rpc0, rpc1;
    logic [BHT_IW-1:0] rbi0, rbi1;
    logic [BTB_IW-1:0] rti0, rti1;
    logic              mis0, mis1, q0, q1;
    logic              wr_btb0, wr_btb1;
    logic [1:0]        ctr0_next, ctr1_base, ctr1_next;
    logic [1:0]        unused_ret_pc_lsbs0, unused_ret_pc_lsbs1;

    assign rpc0 = ret_pc[0 +: XLEN];
    assign rpc1 = ret_pc[XLEN +: XLEN];
    assign rbi0 = rpc0[BHT_IW+1:2];
    assign rbi1 = rpc1[BHT_IW+1:2];
    assign rti0 = rpc0[BTB_IW+1:2];
    assign rti1 = rpc1[BTB_IW+1:2];
    assign unused_ret_pc_lsbs0 = rpc0[1:0];
    assign unused_ret_pc_lsbs1 = rpc1[1:0];

    assign mis0 = ret_ex_take_branch[0] != ret_predict_take_branch[0];
    assign mis1 = ret_ex_take_branch[1] != ret_predict_take_branch[1];
    // A slot-0 mispredict means slot 1 was fetched down the wrong path.
    assign q0   = ret_valid[0];
    assign q1   = ret_valid[1] & ~(ret_valid[0] & mis0);

    assign wr_btb0 = q0 & ret_ex_take_branch[0];
    assign wr_btb1 = q1 & ret_ex_take_branch[1];

    // When both slots hit the same counter, slot 1 steps from slot 0's result.
    assign ctr0_next = ctr_step(bht[rbi0], ret_ex_take_branch[0]);
    assign ctr1_base = (q0 && (rbi0 == rbi1)) ? ctr0_next : bht[rbi1];
    assign ctr1_next = ctr_step(ctr1_base, ret_ex_take_branch[1]);

    // Control state: counters, BTB valid bits, performance counters.
    // Slot 1 writes are issued last so they win on an index collision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
            btb_valid        <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (q0)      bht[rbi0] <= ctr0_next;
            if (q1)      bht[rbi1] <= ctr1_next;
            if (wr_btb0) btb_valid[rti0] <= 1'b1;
            if (wr_btb1) btb_valid[rti1] <= 1'b1;
            branch_count     <= branch_count + {31'd0, q0} + {31'd0, q1};
            mispredict_count <= mispredict_count + {31'd0, (q0 & mis0) | (q1 & mis1)};
        end
    end

    // BTB payload needs no clear: it is qualified by btb_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (wr_btb0) begin
                btb_tag[rti0]    <= rpc0[XLEN-1:BTB_IW+2];
                btb_target[rti0] <= ret_ex_target_pc[0 +: XLEN];
            end
            if (wr_btb1) begin
                btb_tag[rti1]    <= rpc1[XLEN-1:BTB_IW+2];
                btb_target[rti1] <= ret_ex_target_pc[XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  if_valid;
    logic [63:0] if_pc;
    logic [1:0]  predict_take_branch;
    logic [63:0] predict_target_pc;
    logic [1:0]  ret_valid;
    logic [63:0] ret_pc;
    logic [1:0]  ret_ex_take_branch;
    logic [63:0] ret_ex_target_pc;
    logic [1:0]  ret_predict_take_branch;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int passed = 0;
    int fails = 0;

    // Reference model: tables as plain arrays, counters as integers 0..3.
    int          m_ctr [32];
    bit          m_bv  [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_bc, m_mc;

    always #5 clock = ~clock;

    branch_predictor #(.XLEN(32), .BHT_ENTRIES(32), .BTB_ENTRIES(16)) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .predict_take_branch(predict_take_branch),
        .predict_target_pc(predict_target_pc),
        .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_ex_take_branch(ret_ex_take_branch),
        .ret_ex_target_pc(ret_ex_target_pc),
        .ret_predict_take_branch(ret_predict_take_branch),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_ctr[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_bc = 0;
        m_mc = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int bi = int'((pc >> 2) % 32);
        int ti = int'((pc >> 2) % 16);
        return m_bv[ti] && (m_tag[ti] == (pc >> 6)) && (m_ctr[bi] >= 2);
    endfunction

    // Applies the retire rules slot by slot, in age order.
    function automatic void model_edge();
        bit any_mis = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            logic [31:0] pc = ret_pc[s*32 +: 32];
            bit taken = ret_ex_take_branch[s];
            bit wrong = ret_ex_take_branch[s] != ret_predict_take_branch[s];
            bit squashed = (s == 1) && ret_valid[0] &&
                           (ret_ex_take_branch[0] != ret_predict_take_branch[0]);
            if (ret_valid[s] && !squashed) begin
                int bi = int'((pc >> 2) % 32);
                int ti = int'((pc >> 2) % 16);
                m_bc++;
                if (wrong) any_mis = 1;
                m_ctr[bi] = taken ? ((m_ctr[bi] < 3) ? m_ctr[bi] + 1 : 3)
                                  : ((m_ctr[bi] > 0) ? m_ctr[bi] - 1 : 0);
                if (taken) begin
                    m_bv[ti]  = 1;
                    m_tag[ti] = pc >> 6;
                    m_tgt[ti] = ret_ex_target_pc[s*32 +: 32];
                end
            end
        end
        if (any_mis) m_mc++;
    endfunction

    task automatic check_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            logic [31:0] pc = if_pc[s*32 +: 32];
            bit hit = if_valid[s] && model_hit(pc);
            logic [31:0] tgt = hit ? m_tgt[int'((pc >> 2) % 16)] : pc + 32'd4;
            check($sformatf("%s_take%0d", tag, s), {31'd0, predict_take_branch[s]}, {31'd0, hit});
            check($sformatf("%s_tgt%0d", tag, s), predict_target_pc[s*32 +: 32], tgt);
        end
        check({tag, "_bc"}, branch_count, m_bc);
        check({tag, "_mc"}, mispredict_count, m_mc);
    endtask

    // Called at a falling edge with inputs already set.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_if(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        if_valid = v;
        if_pc = {p1, p0};
    endtask

    task automatic set_ret(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [1:0] ex, input logic [31:0] t0, input logic [31:0] t1,
                           input logic [1:0] pr);
        ret_valid = v;
        ret_pc = {p1, p0};
        ret_ex_take_branch = ex;
        ret_ex_target_pc = {t1, t0};
        ret_predict_take_branch = pr;
    endtask

    initial begin
        reset = 1'b0;
        set_if(2'b00, 0, 0);
        set_ret(2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        model_reset();

        // Reset state
        set_if(2'b01, 32'h100, 32'h104);
        #1;
        check("rst_take0", {31'd0, predict_take_branch[0]}, 32'd0);
        check("rst_tgt0", predict_target_pc[31:0], 32'h104);
        check("rst_bc", branch_count, 32'd0);
        check("rst_mc", mispredict_count, 32'd0);
        cycle("rst");
        reset = 1'b1;

        // First taken retire; same-cycle lookup sees old state
        set_ret(2'b01, 32'h100, 0, 2'b01, 32'h200, 0, 2'b00);
        #1;
        check("same_cycle_take", {31'd0, predict_take_branch[0]}, 32'd0);
        cycle("train1");
        set_ret(2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        check("hit_take", {31'd0, predict_take_branch[0]}, 32'd1);
        check("hit_tgt", predict_target_pc[31:0], 32'h200);
        check("hit_bc", branch_count, 32'd1);
        check("hit_mc", mispredict_count, 32'd1);
        cycle("hit");

        // Tag mismatch at the same index
        set_if(2'b11, 32'h180, 32'h100);
        #1;
        check("tagmiss_take", {31'd0, predict_take_branch[0]}, 32'd0);
        check("tagmiss_tgt", predict_target_pc[31:0], 32'h184);
        cycle("tagmiss");

        // Both slots same counter: 10 -> 11, then 11 -> 01
        set_ret(2'b11, 32'h100, 32'h100, 2'b11, 32'h200, 32'h200, 2'b11);
        cycle("dual_t");
        set_ret(2'b11, 32'h100, 32'h100, 2'b00, 0, 0, 2'b00);
        #1;
        check("dual_bc", branch_count, 32'd3);
        cycle("dual_nt");
        set_ret(2'b00, 0, 0, 0, 0, 0, 0);
        set_if(2'b01, 32'h100, 32'h0);
        #1;
        check("dual_nt_take", {31'd0, predict_take_branch[0]}, 32'd0);
        check("dual_nt_bc", branch_count, 32'd5);
        cycle("after_dual");

        // Slot 0 mispredict squashes slot 1
        set_ret(2'b11, 32'h100, 32'h300, 2'b11, 32'h200, 32'h400, 2'b10);
        cycle("squash");
        set_ret(2'b00, 0, 0, 0, 0, 0, 0);
        set_if(2'b10, 32'h0, 32'h300);
        #1;
        check("squash_take1", {31'd0, predict_take_branch[1]}, 32'd0);
        check("squash_bc", branch_count, 32'd6);
        check("squash_mc", mispredict_count, 32'd2);
        cycle("after_squash");

        // Strongly taken, then reset with a concurrent retire
        set_ret(2'b01, 32'h100, 0, 2'b01, 32'h200, 0, 2'b01);
        cycle("strong");
        set_ret(2'b01, 32'h140, 0, 2'b01, 32'h500, 0, 2'b01);
        reset = 1'b0;
        cycle("mid_reset");
        reset = 1'b1;
        set_ret(2'b00, 0, 0, 0, 0, 0, 0);
        set_if(2'b11, 32'h100, 32'h140);
        #1;
        check("postrst_take0", {31'd0, predict_take_branch[0]}, 32'd0);
        check("postrst_take1", {31'd0, predict_take_branch[1]}, 32'd0);
        check("postrst_bc", branch_count, 32'd0);
        cycle("postrst");

        // Randomised phase against the model; small PC pool forces collisions
        for (int n = 0; n < 400; n++) begin
            logic [31:0] p [4];
            for (int k = 0; k < 4; k++)
                p[k] = 32'h1000 | ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 6);
            reset = ($urandom_range(0, 49) != 0);
            set_if(2'($urandom), p[0], p[1]);
            set_ret(2'($urandom), p[2], p[3], 2'($urandom),
                    {$urandom & 32'hFFFF_FFFC}, {$urandom & 32'hFFFF_FFFC}, 2'($urandom));
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor. Supplies per-slot predicted direction and target for the two-wide fetch group and is trained from the two-wide retire stream, whose resolution stage compares its predictions against execute outcomes. Contains a direct-mapped bimodal table of 2-bit saturating counters (BHT), a tagged direct-mapped branch target buffer (BTB), and branch/mispredict performance counters.

## Interface
- `XLEN`, 32: address width.
- `BHT_ENTRIES`, 32: counter entries, power of two.
- `BTB_ENTRIES`, 16: target entries, power of two.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clock`; state is cleared while it is 0.
- `if_valid`  in  2  fetch slot valid.
- `if_pc`  in  2×XLEN  fetch slot PCs.
- `predict_take_branch`  out  2  predicted taken per fetch slot.
- `predict_target_pc`  out  2×XLEN  predicted next PC per fetch slot.
- `ret_valid`  in  2  retire slot holds a retiring branch; slot 0 is older.
- `ret_pc`  in  2×XLEN  PC of the retiring branch.
- `ret_ex_take_branch`  in  2  resolved direction.
- `ret_ex_target_pc`  in  2×XLEN  resolved taken target.
- `ret_predict_take_branch`  in  2  direction predicted at fetch.
- `branch_count`  out  32  number of branches used for training.
- `mispredict_count`  out  32  number of direction mispredicts counted.

## Operation
- Index and tag fields:
  - BHT index: `pc[log2(BHT_ENTRIES)+1:2]`.
  - BTB index: `pc[log2(BTB_ENTRIES)+1:2]`.
  - BTB tag: `pc[XLEN-1:log2(BTB_ENTRIES)+2]`.
- BTB entry fields: valid, tag, target.
- Lookup, per slot, combinational from registered state:
  - hit = `if_valid` AND BTB valid AND tag match AND counter ≥ 2'b10.
  - On hit: `predict_take_branch`=1, `predict_target_pc`=BTB target.
  - Otherwise: `predict_take_branch`=0, `predict_target_pc`=`if_pc`+4, modulo 2^XLEN.
- Retire qualification:
  - Slot 0 trains when `ret_valid[0]`.
  - Slot 1 trains when `ret_valid[1]`, unless slot 0 is valid and `ret_ex_take_branch[0]` != `ret_predict_take_branch[0]`. In that case slot 1 is a squashed younger instruction and is ignored completely: no table update, no counting.
- Training for each qualified slot:
  - Counter saturating increment if taken, saturating decrement if not taken.
  - If taken, write the BTB entry: valid=1, tag, target=`ret_ex_target_pc`.
  - Not-taken never invalidates a BTB entry.
- Same-cycle collisions:
  - Both slots on the same BHT index: apply slot 0 then slot 1 to the counter, saturating at each step. Examples: 10 with taken+taken gives 11; 11 with not-taken+not-taken gives 01; 01 with taken+not-taken gives 01.
  - Both slots writing the same BTB index: slot 1 wins.
- Performance counters:
  - `branch_count` increases by the number of qualified slots (0, 1 or 2).
  - `mispredict_count` increases by 1 when any qualified slot has a direction mismatch. At most 1 per cycle, given the slot 1 gating.
  - Both counters wrap modulo 2^32.
- Reset (`reset`=0 at a rising edge):
  - All counters set to 2'b01, weakly not-taken.
  - All BTB valid bits set to 0.
  - Both performance counters set to 0.
  - This takes priority over any concurrent retire update.

## Timing
- Lookup has zero latency: outputs depend combinationally on `if_pc`/`if_valid` and current state.
- A training update is visible to lookups from the cycle after the retire edge. There is no same-cycle bypass: a lookup in the update cycle sees the old values.
- Output values during and immediately after reset: `predict_take_branch`=0, `predict_target_pc`=`if_pc`+4, `branch_count`=0, `mispredict_count`=0.
- Reset asserted mid-operation discards any update presented in that cycle. Training resumes on the first edge with `reset`=1.
- No handshake. Retire inputs are single-cycle pulses, accepted every cycle.

## Test plan
- Reset, then `if_pc[0]`=0x100, `if_valid`=01 -> `predict_take_branch[0]`=0, target 0x104, both counts 0.
- Retire slot 0: pc 0x100, taken, target 0x200, predicted 0 -> counter 01→10, `branch_count`=1, `mispredict_count`=1. Next cycle, lookup 0x100 -> taken, target 0x200. Same-cycle lookup -> not taken.
- After the previous step, lookup 0x180 (same BHT and BTB index, tag 6 vs 4) -> not taken, target 0x184.
- Both slots retire pc 0x100 taken with counter at 10 -> counter 11. Then both retire not-taken -> 01, and lookup 0x100 -> not taken. `branch_count` increases by 2 in each cycle.
- Slot 0 mispredicts (ex=1, pred=0); slot 1 is valid, pc 0x300, taken -> slot 1 BHT and BTB unchanged, lookup 0x300 -> not taken, `branch_count`+1, `mispredict_count`+1.
- Train 0x100 to strongly taken, then hold `reset`=0 for one cycle while retiring a taken branch at 0x140 -> afterwards lookups of 0x100 and 0x140 are not taken, counts 0.
